// File: rtl/data_mem_arbiter_if.sv
// Requester and data-memory signal bundle for data_mem_arbiter (two requesters, one memory port).
// slave = arbiter view, master = requesters plus memory view.
interface data_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_RW;
  logic [AW-1:0] mem_ADDr;
  logic [DW-1:0] mem_Din;
  logic [DW-1:0] mem_Dout;
  logic [15:0]   xfer_cnt;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_RW, mem_ADDr, mem_Din,
    input  mem_Dout,
    output xfer_cnt
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_RW, mem_ADDr, mem_Din,
    output mem_Dout,
    input  xfer_cnt
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter; ARB_ROUND_ROBIN_EN selects round-robin, else m0 fixed priority.
// Latency gnt->rvalid 2 cycles, one transaction per 3 cycles; losers hold req until gnt (no loss).
module data_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                CLK,
  input  logic                RSTn,
  data_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          sel_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [15:0]   cnt_q;
  logic          pick_m1;
  logic          gnt0, gnt1;
  logic          accept;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_m1_q;

  // On a tie, favour whoever was not served last.
  always_comb pick_m1 = bus.m1_req && (!bus.m0_req || !last_m1_q);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)       last_m1_q <= 1'b1;
    else if (accept) last_m1_q <= pick_m1;
  end
`else
  always_comb pick_m1 = bus.m1_req && !bus.m0_req;
`endif

  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (RSTn && (bus.m0_req || bus.m1_req)) begin
          state_d = ACCESS;
          gnt0    = !pick_m1;
          gnt1    = pick_m1;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = gnt0 || gnt1;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q   <= pick_m1;
        we_q    <= pick_m1 ? bus.m1_we    : bus.m0_we;
        addr_q  <= pick_m1 ? bus.m1_addr  : bus.m0_addr;
        wdata_q <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
      end
      // Writes report zero data so rdata never leaks a stale read.
      if (state_q == ACCESS) rdata_q <= we_q ? '0 : bus.mem_Dout;
      if (state_q == RESP)   cnt_q   <= cnt_q + 16'd1;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = (state_q == RESP) && !sel_q;
  assign bus.m1_rvalid = (state_q == RESP) &&  sel_q;
  assign bus.m0_rdata  = bus.m0_rvalid ? rdata_q : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? rdata_q : '0;

  // Strobe is decoded from live state so an async reset kills it mid-cycle.
  assign bus.mem_RW    = (state_q == ACCESS) && we_q;
  assign bus.mem_ADDr  = addr_q;
  assign bus.mem_Din   = wdata_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: vector table of single-requester transactions
// plus hand-written sequences for contention, reset-in-ACCESS and counter wrap.
module tb_data_mem_arbiter;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] cnt_exp = 16'h0;

  always #5 CLK = ~CLK;

  data_mem_arbiter_if #(.AW(32), .DW(32)) bus();

  data_mem_arbiter #(.AW(32), .DW(32)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  // Word-addressed memory with combinational read.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  always @(posedge CLK) if (bus.mem_RW) mem[bus.mem_ADDr[9:2]] <= bus.mem_Din;
  assign bus.mem_Dout = mem[bus.mem_ADDr[9:2]];

  typedef struct {
    bit          who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit who, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (who) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
  endtask

  // Called just after a negedge in IDLE; returns just after the negedge of the following IDLE cycle.
  task automatic do_txn(input bit who, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
    drive(who, 1'b1, we, addr, wdata);
    #1;
    chk("gnt_winner", who ? bus.m1_gnt : bus.m0_gnt, 1);
    chk("gnt_loser",  who ? bus.m0_gnt : bus.m1_gnt, 0);
    chk("rw_idle",    bus.mem_RW, 0);
    @(negedge CLK);
    drive(who, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("gnt_access", bus.m0_gnt | bus.m1_gnt, 0);
    chk("rw_access",  bus.mem_RW, we);
    chk("addr_access", bus.mem_ADDr, addr);
    if (we) chk("din_access", bus.mem_Din, wdata);
    @(negedge CLK);
    #1;
    chk("rvalid_winner", who ? bus.m1_rvalid : bus.m0_rvalid, 1);
    chk("rvalid_loser",  who ? bus.m0_rvalid : bus.m1_rvalid, 0);
    chk("rdata_resp",    who ? bus.m1_rdata  : bus.m0_rdata, exp_rdata);
    chk("rw_resp",       bus.mem_RW, 0);
    cnt_exp = cnt_exp + 16'd1;
    @(negedge CLK);
    #1;
    chk("rvalid_after", bus.m0_rvalid | bus.m1_rvalid, 0);
    chk("rdata_after",  bus.m0_rdata | bus.m1_rdata, 0);
    chk("xfer_cnt",     bus.xfer_cnt, cnt_exp);
  endtask

  initial begin
    vecs[0] = '{who: 1'b0, we: 1'b1, addr: 32'h10,  wdata: 32'hDEADBEEF, exp_rdata: 32'h0};
    vecs[1] = '{who: 1'b1, we: 1'b0, addr: 32'h10,  wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    vecs[2] = '{who: 1'b1, we: 1'b1, addr: 32'h14,  wdata: 32'hA5A50001, exp_rdata: 32'h0};
    vecs[3] = '{who: 1'b0, we: 1'b0, addr: 32'h14,  wdata: 32'h0,        exp_rdata: 32'hA5A50001};
    vecs[4] = '{who: 1'b0, we: 1'b1, addr: 32'h3FF, wdata: 32'h0BADF00D, exp_rdata: 32'h0};
    vecs[5] = '{who: 1'b1, we: 1'b0, addr: 32'h3FF, wdata: 32'h0,        exp_rdata: 32'h0BADF00D};
    vecs[6] = '{who: 1'b0, we: 1'b0, addr: 32'h10,  wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    vecs[7] = '{who: 1'b1, we: 1'b0, addr: 32'h80,  wdata: 32'h0,        exp_rdata: 32'h0};

    drive(1'b0, 1'b1, 1'b1, 32'h44, 32'h55);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_m0_gnt",   bus.m0_gnt, 0);
    chk("rst_rvalid",   bus.m0_rvalid | bus.m1_rvalid, 0);
    chk("rst_rdata",    bus.m0_rdata | bus.m1_rdata, 0);
    chk("rst_mem_rw",   bus.mem_RW, 0);
    chk("rst_mem_addr", bus.mem_ADDr, 0);
    chk("rst_mem_din",  bus.mem_Din, 0);
    chk("rst_xfer_cnt", bus.xfer_cnt, 0);

    // First accept in the first cycle out of reset.
    @(negedge CLK);
    RSTn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Continuous contention; last served was m1.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    for (int k = 0; k < 4; k++) begin
      bit w;
`ifdef ARB_ROUND_ROBIN_EN
      w = k[0];
`else
      w = 1'b0;
`endif
      #1;
      chk("arb_m0_gnt", bus.m0_gnt, !w);
      chk("arb_m1_gnt", bus.m1_gnt, w);
      @(negedge CLK);
      #1;
      chk("arb_gnt_access", bus.m0_gnt | bus.m1_gnt, 0);
      @(negedge CLK);
      #1;
      chk("arb_rvalid", w ? bus.m1_rvalid : bus.m0_rvalid, 1);
      chk("arb_rdata",  w ? bus.m1_rdata : bus.m0_rdata, w ? 32'hA5A50001 : 32'hDEADBEEF);
      cnt_exp = cnt_exp + 16'd1;
      @(negedge CLK);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("arb_xfer_cnt", bus.xfer_cnt, cnt_exp);

    // Reset during the ACCESS cycle of a write.
    @(negedge CLK);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    #1;
    chk("rstacc_gnt", bus.m0_gnt, 1);
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rstacc_rw_pre", bus.mem_RW, 1);
    RSTn = 1'b0;
    #1;
    chk("rstacc_rw_drop", bus.mem_RW, 0);
    cnt_exp = 16'h0;
    @(negedge CLK);
    #1;
    chk("rstacc_rvalid", bus.m0_rvalid | bus.m1_rvalid, 0);
    chk("rstacc_cnt",    bus.xfer_cnt, cnt_exp);
    RSTn = 1'b1;
    @(negedge CLK);
    #1;
    chk("rstacc_rvalid2", bus.m0_rvalid | bus.m1_rvalid, 0);
    do_txn(1'b1, 1'b0, 32'h20, 32'h0, 32'h0);

    // Counter wrap.
    force dut.cnt_q = 16'hFFFF;
    @(negedge CLK);
    #1;
    chk("wrap_preload", bus.xfer_cnt, 16'hFFFF);
    release dut.cnt_q;
    cnt_exp = 16'hFFFF;
    do_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    chk("wrap_zero", bus.xfer_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width of both requesters and the memory port.
REQ-002 Parameter DW, 32, data width of both requesters and the memory port.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 m0_req / m1_req  input  1  requester N access request, held until mN_gnt.
REQ-006 m0_we / m1_we  input  1  requester N direction: 1 = write, 0 = read.
REQ-007 m0_addr / m1_addr  input  AW  requester N byte address.
REQ-008 m0_wdata / m1_wdata  input  DW  requester N write data.
REQ-009 m0_gnt / m1_gnt  output  1  one-cycle accept pulse to requester N.
REQ-010 m0_rvalid / m1_rvalid  output  1  one-cycle completion pulse to requester N.
REQ-011 m0_rdata / m1_rdata  output  DW  read data, valid while mN_rvalid = 1.
REQ-012 mem_RW  output  1  to data memory: 1 = write, 0 = read.
REQ-013 mem_ADDr  output  AW  to data memory: byte address.
REQ-014 mem_Din  output  DW  to data memory: write data.
REQ-015 mem_Dout  input  DW  from data memory: combinational read data.
REQ-016 xfer_cnt  output  16  count of completed transactions.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on accept, ACCESS->RESP, RESP->IDLE unconditionally.
REQ-018 In IDLE with any mN_req = 1, the winner's mN_gnt is driven 1 combinationally; its we/addr/wdata are latched on that edge.
REQ-019 mN_gnt is 0 in ACCESS and RESP; requests arriving then wait, with no loss.
REQ-020 ACCESS lasts exactly 1 cycle; mem_ADDr/mem_Din come from the latched registers; mem_RW = latched we.
REQ-021 A write commits in memory at the edge ending ACCESS; a read captures mem_Dout into the rdata register on that edge.
REQ-022 In RESP, the winner's mN_rvalid = 1 for exactly 1 cycle; mN_rdata = captured data for reads and 0 for writes; the loser's rvalid stays 0.
REQ-023 Latency: gnt cycle to rvalid cycle = 2 cycles; throughput is 1 transaction per 3 cycles.
REQ-024 mem_RW = 0 in every cycle other than ACCESS-with-write; memory is never written spuriously.
REQ-025 mem_ADDr/mem_Din hold the last latched values outside ACCESS.
REQ-026 Deasserting mN_req after gnt has no effect on the in-flight transaction.
REQ-027 m0_rdata/m1_rdata are 0 whenever the corresponding rvalid = 0.
REQ-028 xfer_cnt increments by 1 in the cycle after each RESP; it wraps from 0xFFFF to 0x0000.
REQ-029 Byte address passes through unmodified; word alignment is the memory's concern.

Reset
REQ-030 RSTn = 0 asynchronously forces: state IDLE, both gnt = 0, both rvalid = 0, both rdata = 0, mem_RW = 0, mem_ADDr = 0, mem_Din = 0, xfer_cnt = 0, and the round-robin pointer to "last = m1".
REQ-031 Reset during ACCESS aborts the transaction: mem_RW drops to 0 immediately, no write commits, and no rvalid is issued.
REQ-032 Leaving reset, the first accept can occur in the first cycle with RSTn = 1.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: simultaneous requests are granted to the requester not granted last; a waiting requester is served within at most one other transaction.
REQ-034 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, with m0 always winning simultaneous requests; the pointer logic is absent.

Verification
REQ-035 After reset, m0 writes 0xDEADBEEF to address 0x10 -> m0_gnt at cycle 0, mem_RW = 1 only in cycle 1, m0_rvalid at cycle 2, xfer_cnt = 1.
REQ-036 m1 reads address 0x10 after the REQ-035 write -> m1_rvalid with m1_rdata = 0xDEADBEEF; mem_RW = 0 throughout.
REQ-037 m0 and m1 request simultaneously and continuously with RR defined -> grants alternate m0, m1, m0, m1 every 3 cycles; without RR -> only m0 is granted.
REQ-038 Reset asserted in the ACCESS cycle of a write of 0x12345678 to address 0x20 -> a subsequent read of 0x20 does not return 0x12345678; no rvalid is issued; xfer_cnt = 0.
REQ-039 Force xfer_cnt to 0xFFFF, then complete one transaction -> xfer_cnt = 0x0000.
REQ-040 m1 drops m1_req in the cycle after m1_gnt -> the transaction still completes with m1_rvalid two cycles after gnt.
